// File: rtl/mul_seq_ctrl.sv
// Multi-cycle sequencer for the MIPS `mul` instruction in EX: radix-2 shift-add
// signed multiply over WIDTH cycles, stalling the pipeline and strobing write-back.
module mul_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [4:0]       rd_in,
  output logic             stall,
  output logic             busy,
  output logic             wb_en,
  output logic [4:0]       rd_out,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi
);

  localparam int PW = 2 * WIDTH;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic             sign_q, sign_d;
  logic [4:0]       rd_q, rd_d;
  logic [4:0]       rd_out_q, rd_out_d;
  logic [WIDTH-1:0] res_lo_q, res_lo_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d;
  logic             wb_en_q, wb_en_d;

  logic [WIDTH-1:0] abs_a, abs_b;
  logic [PW-1:0]    prod;

  // Magnitudes are unsigned WIDTH bits, so the most negative operand still fits.
  assign abs_a = src_a[WIDTH-1] ? -src_a : src_a;
  assign abs_b = src_b[WIDTH-1] ? -src_b : src_b;
  assign prod  = sign_q ? -acc_q : acc_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    sign_d   = sign_q;
    rd_d     = rd_q;
    rd_out_d = rd_out_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    wb_en_d  = 1'b0;

    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            mcand_d  = {{WIDTH{1'b0}}, abs_a};
            mplier_d = abs_b;
            sign_d   = src_a[WIDTH-1] ^ src_b[WIDTH-1];
            rd_d     = rd_in;
            cnt_d    = CNT_INIT;
            acc_d    = '0;
            state_d  = BUSY;
          end
        end
        BUSY: begin
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          if (cnt_q == '0) state_d = DONE;
          else             cnt_d   = cnt_q - 1'b1;
        end
        DONE: begin
          // start is deliberately ignored here so the finished mul cannot re-trigger.
          {res_hi_d, res_lo_d} = prod;
          rd_out_d = rd_q;
          wb_en_d  = 1'b1;
          state_d  = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      sign_q   <= 1'b0;
      rd_q     <= '0;
      rd_out_q <= '0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      wb_en_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      sign_q   <= sign_d;
      rd_q     <= rd_d;
      rd_out_q <= rd_out_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      wb_en_q  <= wb_en_d;
    end
  end

  // Stall drops in DONE so the completed mul can leave EX.
  assign stall     = ((state_q == IDLE) && start && !flush) || (state_q == BUSY);
  assign busy      = (state_q == BUSY);
  assign wb_en     = wb_en_q;
  assign rd_out    = rd_out_q;
  assign result_lo = res_lo_q;
  assign result_hi = res_hi_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed self-checking bench for mul_seq_ctrl (WIDTH=32): latency, signed
// products, flush, mid-run reset, back-to-back issue and idle behaviour.
module tb_mul_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, flush;
  logic [31:0] src_a, src_b;
  logic [4:0]  rd_in;
  logic        stall, busy, wb_en;
  logic [4:0]  rd_out;
  logic [31:0] result_lo, result_hi;

  int checks = 0;
  int failures = 0;
  logic [31:0] last_lo, last_hi;
  logic [4:0]  last_rd;

  mul_seq_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .flush(flush),
    .src_a(src_a), .src_b(src_b), .rd_in(rd_in),
    .stall(stall), .busy(busy), .wb_en(wb_en), .rd_out(rd_out),
    .result_lo(result_lo), .result_hi(result_hi)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; flush = 1'b0;
    src_a = '0; src_b = '0; rd_in = '0;
    next_cycle();
    next_cycle();
    sample();
    checks += 4;
    if (stall !== 1'b0) begin failures++; $display("[TB] FAIL reset_stall: got %b want 0", stall); end
    if (busy !== 1'b0)  begin failures++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    if (wb_en !== 1'b0) begin failures++; $display("[TB] FAIL reset_wb_en: got %b want 0", wb_en); end
    if ({rd_out, result_hi, result_lo} !== 69'd0) begin
      failures++;
      $display("[TB] FAIL reset_results: got rd=%0d hi=%h lo=%h want all 0", rd_out, result_hi, result_lo);
    end
    reset = 1'b0;
    next_cycle();
    last_lo = '0; last_hi = '0; last_rd = '0;
  endtask

  // One full multiply with start held until stall falls (DONE), then released.
  task automatic run_mul(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp_lo, input logic [31:0] exp_hi);
    int  stall_cnt;
    int  busy_cnt;
    int  wb_cnt;
    int  wb_cyc;
    bit  done_seen;
    stall_cnt = 0; busy_cnt = 0; wb_cnt = 0; wb_cyc = -1; done_seen = 1'b0;
    src_a = a; src_b = b; rd_in = rd; start = 1'b1;
    for (int c = 0; c < 45; c++) begin
      if (done_seen) start = 1'b0;
      sample();
      if (stall) stall_cnt++;
      if (busy) busy_cnt++;
      if (wb_en) begin wb_cnt++; wb_cyc = c; end
      if (!stall && start && !done_seen) done_seen = 1'b1;
      next_cycle();
    end
    start = 1'b0;
    sample();
    checks += 6;
    if (stall_cnt != 33) begin failures++; $display("[TB] FAIL %s stall_cycles: got %0d want 33", name, stall_cnt); end
    if (busy_cnt != 32)  begin failures++; $display("[TB] FAIL %s busy_cycles: got %0d want 32", name, busy_cnt); end
    if (wb_cnt != 1 || wb_cyc != 34) begin
      failures++;
      $display("[TB] FAIL %s wb_pulse: got count=%0d cycle=%0d want count=1 cycle=34", name, wb_cnt, wb_cyc);
    end
    if (result_lo !== exp_lo) begin failures++; $display("[TB] FAIL %s result_lo: got %h want %h", name, result_lo, exp_lo); end
    if (result_hi !== exp_hi) begin failures++; $display("[TB] FAIL %s result_hi: got %h want %h", name, result_hi, exp_hi); end
    if (rd_out !== rd) begin failures++; $display("[TB] FAIL %s rd_out: got %0d want %0d", name, rd_out, rd); end
    last_lo = exp_lo; last_hi = exp_hi; last_rd = rd;
    next_cycle();
  endtask

  task automatic test_products();
    run_mul("mul_3x4",    32'd3,        32'd4,        5'd8,  32'h0000000C, 32'h00000000);
    run_mul("mul_m7x5",   32'hFFFFFFF9, 32'h00000005, 5'd2,  32'hFFFFFFDD, 32'hFFFFFFFF);
    run_mul("mul_minxm1", 32'h80000000, 32'hFFFFFFFF, 5'd31, 32'h80000000, 32'h00000000);
    run_mul("mul_maxsq",  32'h7FFFFFFF, 32'h7FFFFFFF, 5'd17, 32'h00000001, 32'h3FFFFFFF);
    run_mul("mul_0xm5",   32'h00000000, 32'hFFFFFFFB, 5'd5,  32'h00000000, 32'h00000000);
    run_mul("mul_m3xm3",  32'hFFFFFFFD, 32'hFFFFFFFD, 5'd12, 32'h00000009, 32'h00000000);
  endtask

  task automatic test_flush();
    int wb_cnt;
    wb_cnt = 0;
    src_a = 32'd9; src_b = 32'd9; rd_in = 5'd3; start = 1'b1;
    for (int c = 0; c < 10; c++) next_cycle();
    flush = 1'b1; start = 1'b0;
    next_cycle();
    flush = 1'b0;
    sample();
    checks += 2;
    if (busy !== 1'b0)  begin failures++; $display("[TB] FAIL flush_busy: got %b want 0", busy); end
    if (stall !== 1'b0) begin failures++; $display("[TB] FAIL flush_stall: got %b want 0", stall); end
    for (int c = 0; c < 40; c++) begin
      sample();
      if (wb_en) wb_cnt++;
      next_cycle();
    end
    // Flush in IDLE must block acceptance.
    start = 1'b1; flush = 1'b1;
    sample();
    checks++;
    if (stall !== 1'b0) begin failures++; $display("[TB] FAIL flush_idle_stall: got %b want 0", stall); end
    next_cycle();
    start = 1'b0; flush = 1'b0;
    sample();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL flush_idle_busy: got %b want 0", busy); end
    for (int c = 0; c < 40; c++) begin
      sample();
      if (wb_en) wb_cnt++;
      next_cycle();
    end
    checks += 2;
    if (wb_cnt != 0) begin failures++; $display("[TB] FAIL flush_no_wb: got %0d pulses want 0", wb_cnt); end
    if ({rd_out, result_hi, result_lo} !== {last_rd, last_hi, last_lo}) begin
      failures++;
      $display("[TB] FAIL flush_hold: got rd=%0d hi=%h lo=%h want rd=%0d hi=%h lo=%h",
               rd_out, result_hi, result_lo, last_rd, last_hi, last_lo);
    end
  endtask

  task automatic test_reset_mid_busy();
    int wb_cnt;
    wb_cnt = 0;
    src_a = 32'd11; src_b = 32'd13; rd_in = 5'd6; start = 1'b1;
    for (int c = 0; c < 10; c++) next_cycle();
    reset = 1'b1; start = 1'b0;
    next_cycle();
    sample();
    checks += 4;
    if (busy !== 1'b0)  begin failures++; $display("[TB] FAIL rstmid_busy: got %b want 0", busy); end
    if (stall !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_stall: got %b want 0", stall); end
    if (wb_en !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_wb_en: got %b want 0", wb_en); end
    if ({rd_out, result_hi, result_lo} !== 69'd0) begin
      failures++;
      $display("[TB] FAIL rstmid_results: got rd=%0d hi=%h lo=%h want all 0", rd_out, result_hi, result_lo);
    end
    next_cycle();
    reset = 1'b0;
    for (int c = 0; c < 40; c++) begin
      sample();
      if (wb_en) wb_cnt++;
      next_cycle();
    end
    checks++;
    if (wb_cnt != 0) begin failures++; $display("[TB] FAIL rstmid_no_wb: got %0d pulses want 0", wb_cnt); end
    last_lo = '0; last_hi = '0; last_rd = '0;
  endtask

  // start stays high through DONE; the second mul enters EX the cycle after DONE.
  task automatic test_back_to_back();
    int          wb_cnt;
    int          done_cnt;
    bit          advance;
    int          wb_cyc [2];
    logic [31:0] wb_lo [2];
    logic [4:0]  wb_rd [2];
    wb_cnt = 0; done_cnt = 0; advance = 1'b0;
    wb_cyc[0] = -1; wb_cyc[1] = -1; wb_lo[0] = '0; wb_lo[1] = '0; wb_rd[0] = '0; wb_rd[1] = '0;
    src_a = 32'd2; src_b = 32'd3; rd_in = 5'd4; start = 1'b1;
    for (int c = 0; c < 100; c++) begin
      if (advance) begin
        advance = 1'b0;
        if (done_cnt == 1) begin src_a = 32'd5; src_b = 32'd6; rd_in = 5'd9; end
        else start = 1'b0;
      end
      sample();
      if (wb_en) begin
        if (wb_cnt < 2) begin wb_cyc[wb_cnt] = c; wb_lo[wb_cnt] = result_lo; wb_rd[wb_cnt] = rd_out; end
        wb_cnt++;
      end
      if (!stall && start) begin done_cnt++; advance = 1'b1; end
      next_cycle();
    end
    start = 1'b0;
    checks += 5;
    if (wb_cnt != 2) begin failures++; $display("[TB] FAIL b2b_pulses: got %0d want 2", wb_cnt); end
    if (wb_cyc[0] != 34 || wb_cyc[1] != 68) begin
      failures++;
      $display("[TB] FAIL b2b_timing: got cycles %0d,%0d want 34,68", wb_cyc[0], wb_cyc[1]);
    end
    if (wb_lo[0] !== 32'd6 || wb_rd[0] !== 5'd4) begin
      failures++;
      $display("[TB] FAIL b2b_first: got lo=%h rd=%0d want lo=00000006 rd=4", wb_lo[0], wb_rd[0]);
    end
    if (wb_lo[1] !== 32'd30 || wb_rd[1] !== 5'd9) begin
      failures++;
      $display("[TB] FAIL b2b_second: got lo=%h rd=%0d want lo=0000001e rd=9", wb_lo[1], wb_rd[1]);
    end
    sample();
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL b2b_idle_after: got busy=%b want 0", busy); end
    next_cycle();
  endtask

  task automatic test_idle_random();
    int bad;
    bad = 0;
    start = 1'b0; flush = 1'b0;
    for (int c = 0; c < 20; c++) begin
      src_a = $urandom; src_b = $urandom; rd_in = 5'($urandom_range(0, 31));
      sample();
      checks++;
      if ({stall, busy, wb_en} !== 3'b000) begin
        failures++; bad++;
        $display("[TB] FAIL idle_quiet: cycle %0d got stall=%b busy=%b wb_en=%b want 0,0,0", c, stall, busy, wb_en);
      end
      next_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_products();
    test_flush();
    test_reset_mid_busy();
    test_back_to_back();
    test_idle_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul_seq_ctrl.md
Name: mul_seq_ctrl

Overview:
- Multi-cycle sequencer for the `mul` instruction (opcode 0x1c) in the EX stage of the MIPS pipeline.
- Runs an iterative radix-2 shift-add signed multiply over WIDTH cycles and holds the pipeline with `stall` while it runs.
- Returns the low product word and destination register to write-back with a one-cycle `wb_en` pulse.
- Sits beside the ALU. Its `start` comes from the EX-stage copy of the decoder's mul flag.

Parameters:
- WIDTH, 32, operand width in bits; product is 2*WIDTH.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  EX stage holds a valid `mul`; level signal, held while the pipeline is stalled.
- flush  input  1  kill the in-flight multiply (branch/exception flush).
- src_a  input  WIDTH  rs value, two's complement.
- src_b  input  WIDTH  rt value, two's complement.
- rd_in  input  5  destination register of the `mul`.
- stall  output  1  freeze PC/IF/ID/EX pipeline registers.
- busy  output  1  state is BUSY.
- wb_en  output  1  one-cycle write-back strobe.
- rd_out  output  5  destination register for write-back.
- result_lo  output  WIDTH  low word of the product (the `mul` result).
- result_hi  output  WIDTH  high word of the product.

Behaviour:
- Clock and reset: one clock, `clk`; `reset` is synchronous and active-high.
- Reset values: state=IDLE; counter, accumulator, multiplicand, multiplier, sign, rd_out, result_lo, result_hi all 0.
- FSM states: IDLE, BUSY, DONE.
- IDLE, `start`=1 and `flush`=0: capture |src_a| and |src_b| (unsigned WIDTH bits, so |-2^(WIDTH-1)| is representable).
  - Also capture sign = src_a[MSB]^src_b[MSB], rd_in, and counter=WIDTH-1.
  - Clear the 2*WIDTH accumulator. Go to BUSY.
- IDLE otherwise: stay in IDLE.
- BUSY, each cycle:
  - If multiplier LSB=1, add the multiplicand into the accumulator.
  - Shift the multiplicand left 1 and the multiplier right 1.
  - If counter==0, go to DONE; else decrement the counter.
- DONE: register {result_hi,result_lo} = sign ? -acc : acc (2*WIDTH two's complement). Go to IDLE unconditionally. `start` is not sampled in DONE.
- Outputs:
  - stall = (IDLE & start & ~flush) | BUSY. This is combinational; stall is 0 in DONE so the finished `mul` leaves EX.
  - busy = (state==BUSY).
  - wb_en = 1 for exactly the cycle after DONE, registered together with the results.
  - rd_out, result_lo and result_hi hold their values until the next completion.
- Latency: `start` seen in IDLE at cycle 0.
  - BUSY spans cycles 1..WIDTH.
  - DONE is cycle WIDTH+1; wb_en and valid results appear at cycle WIDTH+2.
  - stall is high for cycles 0..WIDTH (WIDTH+1 cycles).
- Back-to-back `mul`: the next instruction enters EX after DONE and is accepted from IDLE. The minimum start-to-start spacing is WIDTH+2 cycles.
- Flush:
  - In BUSY or DONE: next state IDLE, no wb_en, results unchanged.
  - In IDLE: suppresses acceptance.
  - Flush has priority over every other transition.
- Reset mid-operation: immediate return to reset values; no wb_en.
- Zero operands: no early exit. Latency is fixed regardless of data.
- Operands are sampled only at acceptance. Changes on src_a, src_b or rd_in during BUSY are ignored.
- No overflow flag: `mul` discards result_hi architecturally, and result_hi is exported for future mult/mfhi.

Test Plan:
- 3 × 4, rd_in=8 → stall high 33 cycles; wb_en pulse at cycle 34; result_lo=0x0000000C, result_hi=0, rd_out=8.
- -7 × 5 (0xFFFFFFF9 × 0x00000005) → result_lo=0xFFFFFFDD, result_hi=0xFFFFFFFF.
- 0x80000000 × 0xFFFFFFFF → result_lo=0x80000000, result_hi=0x00000000. Also 0x7FFFFFFF × 0x7FFFFFFF → hi=0x3FFFFFFF, lo=0x00000001.
- Flush asserted at BUSY cycle 10 → state IDLE next cycle, stall drops, no wb_en, previous results retained. Reset asserted mid-BUSY gives the same outcome with all outputs returning to 0.
- Two `mul`s back to back (2×3 to rd 4, then 5×6 to rd 9) → two wb_en pulses 34 cycles apart, results 6 and 30. The first instruction's held `start` in DONE causes no re-trigger.
- `start`=0 throughout with random operands → stall, busy and wb_en stay 0.
